button_pulse_gen: RTL

Front-end for the up/down counter: takes two raw, bouncing, active-low push-buttons and produces the counter's `count_up` / `count_down` strobes. Each button is synchronised and debounced, then an FSM emits exactly one active-low, one-cycle pulse per press, plus optional auto-repeat while held. Outputs connect directly to the counter's `count_up` / `count_down` inputs.

---
 rtl/button_pulse_pkg.sv | 21 ++
 rtl/button_debounce.sv | 51 +++++
 rtl/button_pulse_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/button_pulse_pkg.sv
// Shared constants for button_pulse_gen: FSM state encodings, default
// parameter values and the counter-width helper.
package button_pulse_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned REPEAT_DELAY_DEF    = 16;
  localparam int unsigned REPEAT_PERIOD_DEF   = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD_UP = 2'd1;
  localparam logic [1:0] ST_HOLD_DN = 2'd2;
  localparam logic [1:0] ST_BOTH    = 2'd3;

  // Counter wide enough to hold n-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability-counter debounce for one active-low
// button; stable_n only follows the synced input after DEBOUNCE_CYCLES agreeing samples.
module button_debounce
  import button_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic stable_n
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_n = stable_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced up/down buttons to one-cycle active-low count strobes.
// Define BUTTON_AUTO_REPEAT_EN to add auto-repeat pulses while a single button is held.
module button_pulse_gen
  import button_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic en,
  output logic count_up,
  output logic count_down
);

  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_cfg
      $error("button_pulse_gen: illegal parameter value");
    end
  endgenerate

  logic   up_stable_n, dn_stable_n;
  logic   up_held, dn_held;
  logic   fire_up, fire_dn;
  state_t state_q, state_d;
  logic   count_up_q, count_up_d;
  logic   count_down_q, count_down_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (btn_up_n),
    .stable_n (up_stable_n)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (btn_down_n),
    .stable_n (dn_stable_n)
  );

  assign up_held = ~up_stable_n;
  assign dn_held = ~dn_stable_n;

  // Press-tracking FSM; en only masks the strobes, never the transitions.
  always_comb begin
    state_d = state_q;
    fire_up = 1'b0;
    fire_dn = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (up_held && dn_held) begin
          state_d = ST_BOTH;
        end else if (up_held) begin
          state_d = ST_HOLD_UP;
          fire_up = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_d   = REP_W'(REPEAT_DELAY - 1);
`endif
        end else if (dn_held) begin
          state_d = ST_HOLD_DN;
          fire_dn = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_d   = REP_W'(REPEAT_DELAY - 1);
`endif
        end
      end
      ST_HOLD_UP: begin
        if (!up_held) begin
          state_d = ST_IDLE;
        end else if (dn_held) begin
          state_d = ST_BOTH;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (rep_q == '0) begin
            fire_up = 1'b1;
            rep_d   = REP_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_d = rep_q - REP_W'(1);
          end
`endif
        end
      end
      ST_HOLD_DN: begin
        if (!dn_held) begin
          state_d = ST_IDLE;
        end else if (up_held) begin
          state_d = ST_BOTH;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (rep_q == '0) begin
            fire_dn = 1'b1;
            rep_d   = REP_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_d = rep_q - REP_W'(1);
          end
`endif
        end
      end
      default: begin
        if (!up_held && !dn_held) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    count_up_d   = ~(fire_up & en);
    count_down_d = ~(fire_dn & en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_up_q   <= 1'b1;
      count_down_q <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_up_q   <= count_up_d;
      count_down_q <= count_down_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign count_up   = count_up_q;
  assign count_down = count_down_q;

endmodule
